// File: rtl/sound_pkg.sv
// Shared constants for the PWM audio output path: sample width, period
// marker and the default silence level.
package sound_pkg;
   localparam int SAMPLE_W = 8;
   localparam logic [SAMPLE_W-1:0] PERIOD_LAST      = 8'hFF;
   localparam logic [SAMPLE_W-1:0] MIDSCALE_DEFAULT = 8'h80;
endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with occupancy count; head data is read combinationally
// so a pop can load it into the level register on the same edge.
module sample_fifo
   import sound_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = SAMPLE_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             push_data,
   output logic [W-1:0]             head_data,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [FW-1:0]   fill_reg;
   logic            do_push;
   logic            do_pop;

   // Full/empty come from the registered count only, so a same-edge pop
   // never makes room for a push.
   assign full    = (fill_reg == DEPTH_F);
   assign empty   = (fill_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign fill      = fill_reg;
   assign head_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   fill_reg <= fill_reg + FW'(1);
            2'b01:   fill_reg <= fill_reg - FW'(1);
            default: fill_reg <= fill_reg;
         endcase
      end
   end
endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: buffers samples in a FIFO, loads a new duty level at each
// period end, and compares the upstream ramp against the current level.
module pwm_audio_out
   import sound_pkg::*;
#(
   parameter int                    DEPTH    = 4,
   parameter logic [SAMPLE_W-1:0]   MIDSCALE = MIDSCALE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SAMPLE_W-1:0]      count,
   input  logic [SAMPLE_W-1:0]      sample,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic                     clear_underrun,
   output logic                     pwm_out,
   output logic [SAMPLE_W-1:0]      level,
   output logic                     underrun,
   output logic [$clog2(DEPTH):0]   fill
);
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [SAMPLE_W-1:0]   head_data;
   logic                  push;
   logic                  pop;
   logic                  period_end;

   logic [SAMPLE_W-1:0]   level_reg;
   logic                  pwm_reg;
   logic                  underrun_reg;

   assign sample_ready = !fifo_full;
   assign push         = sample_valid && sample_ready;
   assign period_end   = (count == PERIOD_LAST);
   assign pop          = period_end && !fifo_empty;

   sample_fifo #(
      .DEPTH (DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (sample),
      .head_data (head_data),
      .fill      (fill),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The compare uses the level held before this edge, so the level change
   // at period end takes effect from the first cycle of the next period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_reg    <= MIDSCALE;
         pwm_reg      <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         pwm_reg <= (count < level_reg);
         if (pop) begin
            level_reg <= head_data;
         end
         if (period_end && fifo_empty) begin
            underrun_reg <= 1'b1;
         end else if (clear_underrun) begin
            underrun_reg <= 1'b0;
         end
      end
   end

   assign pwm_out  = pwm_reg;
   assign level    = level_reg;
   assign underrun = underrun_reg;
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: one task per scenario, expected values
// worked out by hand from the ramp/level relationship.
module tb_pwm_audio_out;
   logic         clk;
   logic         reset;
   logic [7:0]   count;
   logic [7:0]   sample;
   logic         sample_valid;
   logic         sample_ready;
   logic         clear_underrun;
   logic         pwm_out;
   logic [7:0]   level;
   logic         underrun;
   logic [2:0]   fill;

   int checks;
   int failures;

   pwm_audio_out #(.DEPTH(4), .MIDSCALE(8'h80)) dut (
      .clk            (clk),
      .reset          (reset),
      .count          (count),
      .sample         (sample),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .clear_underrun (clear_underrun),
      .pwm_out        (pwm_out),
      .level          (level),
      .underrun       (underrun),
      .fill           (fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      count          = 8'h00;
      sample         = 8'h00;
      sample_valid   = 1'b0;
      clear_underrun = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic push_one(input logic [7:0] value);
      sample       = value;
      sample_valid = 1'b1;
      count        = 8'h00;
      tick();
      sample_valid = 1'b0;
      $display("push %02h -> fill=%0d ready=%0b", value, fill, sample_ready);
   endtask

   task automatic period_end_tick();
      count = 8'hFF;
      tick();
      count = 8'h00;
      $display("period end -> level=%02h fill=%0d underrun=%0b", level, fill, underrun);
   endtask

   task automatic run_period(output int highs);
      highs = 0;
      for (int c = 0; c < 256; c++) begin
         count = 8'(c);
         tick();
         if (pwm_out) highs++;
      end
      count = 8'h00;
      $display("period -> highs=%0d level=%02h underrun=%0b", highs, level, underrun);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
      checks++; if (level !== 8'h80) begin failures++; $display("FAIL reset_level got=%02h exp=80", level); end
      checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%0b exp=0", pwm_out); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%0b exp=0", underrun); end
      checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", sample_ready); end
      $display("reset -> fill=%0d level=%02h pwm=%0b", fill, level, pwm_out);
   endtask

   task automatic test_silence();
      int highs;
      do_reset();
      highs = 0;
      for (int c = 0; c < 255; c++) begin
         count = 8'(c);
         tick();
         if (pwm_out) highs++;
      end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL silence_early_underrun got=%0b exp=0", underrun); end
      count = 8'hFF;
      tick();
      if (pwm_out) highs++;
      count = 8'h00;
      $display("silence period -> highs=%0d underrun=%0b", highs, underrun);
      checks++; if (highs !== 128) begin failures++; $display("FAIL silence_highs got=%0d exp=128", highs); end
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL silence_underrun got=%0b exp=1", underrun); end
      checks++; if (level !== 8'h80) begin failures++; $display("FAIL silence_level got=%02h exp=80", level); end
   endtask

   task automatic test_two_samples();
      int highs;
      do_reset();
      push_one(8'h40);
      push_one(8'hC0);
      checks++; if (fill !== 3'd2) begin failures++; $display("FAIL two_fill got=%0d exp=2", fill); end
      run_period(highs);
      checks++; if (highs !== 128) begin failures++; $display("FAIL two_p0_highs got=%0d exp=128", highs); end
      checks++; if (level !== 8'h40) begin failures++; $display("FAIL two_level0 got=%02h exp=40", level); end
      run_period(highs);
      checks++; if (highs !== 64) begin failures++; $display("FAIL two_p1_highs got=%0d exp=64", highs); end
      checks++; if (level !== 8'hC0) begin failures++; $display("FAIL two_level1 got=%02h exp=C0", level); end
      run_period(highs);
      checks++; if (highs !== 192) begin failures++; $display("FAIL two_p2_highs got=%0d exp=192", highs); end
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL two_underrun got=%0b exp=1", underrun); end
   endtask

   task automatic test_full();
      logic [7:0] exp_level;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         logic exp_ready;
         exp_ready = (i < 4);
         checks++; if (sample_ready !== exp_ready) begin failures++; $display("FAIL full_ready_%0d got=%0b exp=%0b", i, sample_ready, exp_ready); end
         push_one(8'(8'h11 * (i + 1)));
      end
      checks++; if (fill !== 3'd4) begin failures++; $display("FAIL full_fill got=%0d exp=4", fill); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL full_flag got=%0b exp=0", underrun); end
      for (int i = 0; i < 4; i++) begin
         period_end_tick();
         exp_level = 8'(8'h11 * (i + 1));
         checks++; if (level !== exp_level) begin failures++; $display("FAIL full_drain_%0d got=%02h exp=%02h", i, level, exp_level); end
      end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL full_drain_underrun got=%0b exp=0", underrun); end
      period_end_tick();
      checks++; if (level !== 8'h44) begin failures++; $display("FAIL full_hold got=%02h exp=44", level); end
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL full_empty_underrun got=%0b exp=1", underrun); end
   endtask

   task automatic test_coincident();
      int highs;
      do_reset();
      sample       = 8'h5A;
      sample_valid = 1'b1;
      count        = 8'hFF;
      tick();
      sample_valid = 1'b0;
      count        = 8'h00;
      $display("push 5A at period end -> fill=%0d level=%02h underrun=%0b", fill, level, underrun);
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL coin_underrun got=%0b exp=1", underrun); end
      checks++; if (fill !== 3'd1) begin failures++; $display("FAIL coin_fill got=%0d exp=1", fill); end
      checks++; if (level !== 8'h80) begin failures++; $display("FAIL coin_level got=%02h exp=80", level); end
      run_period(highs);
      checks++; if (level !== 8'h5A) begin failures++; $display("FAIL coin_next_level got=%02h exp=5A", level); end
      run_period(highs);
      checks++; if (highs !== 90) begin failures++; $display("FAIL coin_highs got=%0d exp=90", highs); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push_one(8'hA1);
      push_one(8'hB2);
      sample       = 8'hC3;
      sample_valid = 1'b1;
      count        = 8'hFF;
      tick();
      sample_valid = 1'b0;
      count        = 8'h00;
      $display("push C3 with pop -> fill=%0d level=%02h", fill, level);
      checks++; if (fill !== 3'd2) begin failures++; $display("FAIL b2b_fill got=%0d exp=2", fill); end
      checks++; if (level !== 8'hA1) begin failures++; $display("FAIL b2b_level0 got=%02h exp=A1", level); end
      period_end_tick();
      checks++; if (level !== 8'hB2) begin failures++; $display("FAIL b2b_level1 got=%02h exp=B2", level); end
      period_end_tick();
      checks++; if (level !== 8'hC3) begin failures++; $display("FAIL b2b_level2 got=%02h exp=C3", level); end
      checks++; if (fill !== 3'd0) begin failures++; $display("FAIL b2b_fill_end got=%0d exp=0", fill); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL b2b_underrun got=%0b exp=0", underrun); end
   endtask

   task automatic test_extremes();
      int highs;
      do_reset();
      push_one(8'h00);
      push_one(8'hFF);
      period_end_tick();
      checks++; if (level !== 8'h00) begin failures++; $display("FAIL ext_level0 got=%02h exp=00", level); end
      run_period(highs);
      checks++; if (highs !== 0) begin failures++; $display("FAIL ext_zero_highs got=%0d exp=0", highs); end
      run_period(highs);
      checks++; if (highs !== 255) begin failures++; $display("FAIL ext_full_highs got=%0d exp=255", highs); end
   endtask

   task automatic test_clear_underrun();
      do_reset();
      period_end_tick();
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL clr_set got=%0b exp=1", underrun); end
      clear_underrun = 1'b1;
      count          = 8'hFF;
      tick();
      count = 8'h00;
      $display("clear with empty period end -> underrun=%0b", underrun);
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%0b exp=1", underrun); end
      tick();
      clear_underrun = 1'b0;
      $display("clear -> underrun=%0b", underrun);
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL clr_cleared got=%0b exp=0", underrun); end
   endtask

   task automatic test_async_reset();
      do_reset();
      push_one(8'h10);
      push_one(8'h20);
      push_one(8'h30);
      count = 8'h70;
      tick();
      checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL ares_pwm_before got=%0b exp=1", pwm_out); end
      checks++; if (fill !== 3'd3) begin failures++; $display("FAIL ares_fill_before got=%0d exp=3", fill); end
      #1;
      reset = 1'b0;
      #1;
      $display("async reset -> fill=%0d level=%02h pwm=%0b", fill, level, pwm_out);
      checks++; if (fill !== 3'd0) begin failures++; $display("FAIL ares_fill got=%0d exp=0", fill); end
      checks++; if (level !== 8'h80) begin failures++; $display("FAIL ares_level got=%02h exp=80", level); end
      checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL ares_pwm got=%0b exp=0", pwm_out); end
      checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL ares_ready got=%0b exp=1", sample_ready); end
      tick();
      reset = 1'b1;
      period_end_tick();
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ares_underrun got=%0b exp=1", underrun); end
      checks++; if (level !== 8'h80) begin failures++; $display("FAIL ares_level_hold got=%02h exp=80", level); end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b0;
      count          = 8'h00;
      sample         = 8'h00;
      sample_valid   = 1'b0;
      clear_underrun = 1'b0;
      test_reset();
      test_silence();
      test_two_samples();
      test_full();
      test_coincident();
      test_back_to_back();
      test_extremes();
      test_clear_underrun();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 Parameter DEPTH, default 4: sample FIFO entries; power of two, 2..16.
REQ-002 Parameter MIDSCALE, default 8'h80: silence level loaded at reset.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: reset is asynchronous and active-low.
REQ-005 count  input  8: free-running ramp from the upstream 8-bit counter; 8'hFF marks the last cycle of a PWM period.
REQ-006 sample  input  8: unsigned audio sample; 0 is minimum, 255 is maximum.
REQ-007 sample_valid  input  1: sample presented this cycle.
REQ-008 sample_ready  output  1: block accepts a sample this cycle.
REQ-009 clear_underrun  input  1: synchronous clear of the underrun flag.
REQ-010 pwm_out  output  1: registered PWM audio bit.
REQ-011 level  output  8: duty level currently being played.
REQ-012 underrun  output  1: sticky flag set when a period ends with an empty FIFO.
REQ-013 fill  output  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

Function
REQ-014 Push occurs when sample_valid and sample_ready are both 1 at a rising edge; the sample enters the FIFO tail.
REQ-015 sample_ready = 1 when fill < DEPTH; it is derived from registered fill only; a same-cycle pop does not admit a push when full.
REQ-016 sample_valid with sample_ready = 0 is ignored; no data is lost from the FIFO and no flag is set.
REQ-017 Period end is any rising edge at which count == 8'hFF.
REQ-018 At period end with fill > 0: FIFO head pops into level, and the new level is visible the next cycle.
REQ-019 At period end with fill == 0: level holds its value and underrun is set to 1.
REQ-020 Simultaneous push and period end with fill == 0: pop sees empty, underrun is set, and the pushed sample is stored with fill = 1.
REQ-021 Simultaneous push and pop with 0 < fill < DEPTH: fill is unchanged and order is preserved FIFO.
REQ-022 Each edge: pwm_out <= (count < level), using level before any same-edge update; duty = level/256 (level 0 gives constant 0, level 255 gives 255/256).
REQ-023 clear_underrun clears underrun; a same-edge set wins over clear.
REQ-024 Nonconsecutive or jumping count values are legal; only count == 8'hFF and the compare matter.

Reset
REQ-025 On reset low, asynchronously: FIFO flushed, fill = 0, level = MIDSCALE, pwm_out = 0, underrun = 0, sample_ready = 1.
REQ-026 Reset asserted mid-period or mid-handshake discards all queued samples; the first period end after release with no push sets underrun.
REQ-027 The first rising edge after reset release performs normal operation; no dead cycle is inserted.

Structure
REQ-028 Shared package sound_pkg holds SAMPLE_W = 8, PERIOD_LAST = 8'hFF and MIDSCALE default.
REQ-029 The FIFO is a sub-module sample_fifo (push, pop, data in/out, fill, full, empty, same clock and reset).
REQ-030 The top level contains only the handshake, period-end detect, level register, compare and underrun logic.

Verification
REQ-031 Reset released, no pushes, count 0..255 -> pwm_out high for 128 cycles per period; underrun = 1 after the first 8'hFF.
REQ-032 Push 8'h40, 8'hC0, then run two periods -> level 8'h40 then 8'hC0; pwm_out high counts 64 then 192.
REQ-033 Push 5 samples with DEPTH = 4 and no period end -> sample_ready = 0 after 4; 5th held off; fill = 4.
REQ-034 Push coincident with count == 8'hFF at fill = 0 -> underrun = 1, fill = 1, level unchanged; the next period plays the pushed value.
REQ-035 Push level 8'h00 and 8'hFF -> pwm_out constant 0, then high 255 of 256 cycles.
REQ-036 Reset pulsed at count = 8'h70 with fill = 3 -> fill = 0, level = 8'h80, pwm_out = 0 immediately, without waiting for a clock edge.
